// File: rtl/mips_multi_cycle_core.sv
// Multi-cycle MIPS integer core: R-type ALU, addi, lw, sw, beq over a shared ALU.
// Define MIPS_MULTI_CYCLE_ILLEGAL_TRAP_EN to halt on illegal instructions instead of retiring them as NOPs.
module mips_multi_cycle_core #(
  parameter int                  DMEM_DEPTH = 64,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [31:0]         instr_data,
  output logic                instr_ready,
  output logic [PC_WIDTH-1:0] pc,
  output logic                result_valid,
  output logic [31:0]         alu_result,
  output logic [31:0]         write_data,
  output logic                illegal
);

  localparam int AW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  state_t state, next_state;

  logic [31:0] ir, a_reg, b_reg, imm_ext, alu_out, mdr;
  logic [31:0] rf   [32];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_dest;
  logic        is_rtype, is_addi, is_lw, is_sw, is_beq, funct_ok, legal;
  logic [31:0] alu_y, wb_value, br_off;
  logic [AW-1:0] mem_idx;
  logic [PC_WIDTH-1:0] pc_plus4, br_target, pc_next;

  logic        ir_load, ab_load, alu_load, mdr_load, mem_we, rf_we, retire;
  logic [31:0] retire_alu, retire_wd;

  // Instruction decode from the IR
  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign funct_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  assign legal    = (is_rtype && funct_ok) || is_addi || is_lw || is_sw || is_beq;

  assign wb_dest  = is_rtype ? rd : rt;
  assign wb_value = is_lw ? mdr : alu_out;
  assign mem_idx  = alu_out[AW+1:2];

  assign br_off    = {imm_ext[29:0], 2'b00};
  assign pc_plus4  = pc + PC_WIDTH'(4);
  assign br_target = pc_plus4 + PC_WIDTH'($signed(br_off));

  assign instr_ready = (state == S_IDLE);

  always_comb begin
    alu_y = a_reg + imm_ext;
    if (is_rtype) begin
      case (funct)
        F_SUB:   alu_y = a_reg - b_reg;
        F_AND:   alu_y = a_reg & b_reg;
        F_OR:    alu_y = a_reg | b_reg;
        F_SLT:   alu_y = {31'b0, $signed(a_reg) < $signed(b_reg)};
        default: alu_y = a_reg + b_reg;
      endcase
    end else if (is_beq) begin
      alu_y = a_reg - b_reg;
    end
  end

`ifdef MIPS_MULTI_CYCLE_ILLEGAL_TRAP_EN
  logic halt_set;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    ir_load    = 1'b0;
    ab_load    = 1'b0;
    alu_load   = 1'b0;
    mdr_load   = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    retire     = 1'b0;
    retire_alu = '0;
    retire_wd  = '0;
    pc_next    = pc_plus4;
`ifdef MIPS_MULTI_CYCLE_ILLEGAL_TRAP_EN
    halt_set   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          ir_load    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
`ifdef MIPS_MULTI_CYCLE_ILLEGAL_TRAP_EN
          halt_set   = 1'b1;
          next_state = S_HALT;
`else
          retire     = 1'b1;
          next_state = S_IDLE;
`endif
        end else begin
          ab_load    = 1'b1;
          next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_load = 1'b1;
        if (is_beq) begin
          retire     = 1'b1;
          retire_alu = alu_y;
          pc_next    = (a_reg == b_reg) ? br_target : pc_plus4;
          next_state = S_IDLE;
        end else if (is_lw || is_sw) begin
          next_state = S_MEMORY;
        end else begin
          next_state = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (is_sw) begin
          mem_we     = 1'b1;
          retire     = 1'b1;
          retire_alu = alu_out;
          next_state = S_IDLE;
        end else begin
          mdr_load   = 1'b1;
          next_state = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        rf_we      = 1'b1;
        retire     = 1'b1;
        retire_alu = alu_out;
        retire_wd  = wb_value;
        next_state = S_IDLE;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_ext <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      if (ir_load) ir <= instr_data;
      if (ab_load) begin
        a_reg   <= rf[rs];
        b_reg   <= rf[rt];
        imm_ext <= {{16{ir[15]}}, ir[15:0]};
      end
      if (alu_load) alu_out <= alu_y;
      if (mdr_load) mdr <= dmem[mem_idx];
    end
  end

  // NOTE: the register file is cleared on reset, but data memory deliberately keeps its contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && wb_dest != 5'd0) begin
      rf[wb_dest] <= wb_value;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) dmem[mem_idx] <= b_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= PC_RESET;
      result_valid <= 1'b0;
      alu_result   <= '0;
      write_data   <= '0;
    end else begin
      result_valid <= retire;
      if (retire) begin
        pc         <= pc_next;
        alu_result <= retire_alu;
        write_data <= retire_wd;
      end
    end
  end

`ifdef MIPS_MULTI_CYCLE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        illegal <= 1'b0;
    else if (halt_set) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multi_cycle_core.sv
// Directed bench for mips_multi_cycle_core: latency, results, pc flow, reset and illegal handling.
module tb_mips_multi_cycle_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        instr_ready;
  logic [31:0] pc;
  logic        result_valid;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  mips_multi_cycle_core #(.DMEM_DEPTH(64), .PC_WIDTH(32), .PC_RESET(32'h0)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .result_valid (result_valid),
    .alu_result   (alu_result),
    .write_data   (write_data),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one instruction and checks latency to result_valid and the retired write_data.
  task automatic run_instr(input string tag, input logic [31:0] instr,
                           input int exp_lat, input logic [31:0] exp_wd);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      seen = instr_ready;
      n++;
    end
    check({tag, " ready"}, 32'(seen), 32'd1);
    instr_valid = 1'b1;
    instr_data  = instr;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge clk);
      n++;
      #1 seen = result_valid;
    end
    check({tag, " latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
    check({tag, " write_data"}, write_data, exp_wd);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = '0;
    #2;
    check("rst pc", pc, 32'h0);
    check("rst alu_result", alu_result, 32'h0);
    check("rst write_data", write_data, 32'h0);
    check("rst result_valid", 32'(result_valid), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst instr_ready", 32'(instr_ready), 32'd1);

    run_instr("addi1", 32'h20010005, 3, 32'h5);
    check("addi1 alu_result", alu_result, 32'h5);
    check("addi1 pc", pc, 32'h4);
    @(posedge clk); #1;
    check("pulse one cycle", 32'(result_valid), 32'd0);
    check("write_data hold", write_data, 32'h5);

    run_instr("addi2", 32'h2002FFF9, 3, 32'hFFFFFFF9);
    run_instr("add3", 32'h00221820, 3, 32'hFFFFFFFE);
    run_instr("slt4", 32'h0041202A, 3, 32'h1);
    check("slt4 pc", pc, 32'h10);

    run_instr("beq taken", 32'h10210003, 2, 32'h0);
    check("beq taken pc", pc, 32'h20);
    check("beq taken alu", alu_result, 32'h0);
    run_instr("beq not", 32'h10220003, 2, 32'h0);
    check("beq not pc", pc, 32'h24);
    check("beq not alu", alu_result, 32'hC);

    run_instr("sub9", 32'h00224822, 3, 32'hC);
    run_instr("or10", 32'h00225025, 3, 32'hFFFFFFFD);
    run_instr("and11", 32'h00225824, 3, 32'h1);
    check("and11 pc", pc, 32'h30);
    run_instr("beq back", 32'h1000FFFE, 2, 32'h0);
    check("beq back pc", pc, 32'h2C);

    run_instr("sw", 32'hAC010008, 3, 32'h0);
    check("sw alu_result", alu_result, 32'h8);
    run_instr("lw wrap", 32'h8C050108, 4, 32'h5);
    check("lw alu_result", alu_result, 32'h108);
    check("lw pc", pc, 32'h34);

    run_instr("addi r0", 32'h20000009, 3, 32'h9);
    run_instr("add r0", 32'h00003020, 3, 32'h0);
    check("add r0 pc", pc, 32'h3C);

    // Reset while addi $7,$0,1 sits in EXECUTE.
    @(negedge clk);
    check("midrst ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr_data  = 32'h20070001;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst pc", pc, 32'h0);
    check("midrst alu_result", alu_result, 32'h0);
    check("midrst write_data", write_data, 32'h0);
    check("midrst result_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst ready after", 32'(instr_ready), 32'd1);
    run_instr("add8", 32'h00E04020, 3, 32'h0);
    check("add8 pc", pc, 32'h4);
    run_instr("lw keep", 32'h8C0D0008, 4, 32'h5);
    check("lw keep pc", pc, 32'h8);

`ifdef MIPS_MULTI_CYCLE_ILLEGAL_TRAP_EN
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = 32'hFC0D6800;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("trap illegal", 32'(illegal), 32'd1);
    check("trap ready", 32'(instr_ready), 32'd0);
    check("trap pc", pc, 32'h8);
    check("trap result_valid", 32'(result_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("trap rst illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("trap rst ready", 32'(instr_ready), 32'd1);
`else
    run_instr("bad opcode", 32'hFC0D6800, 1, 32'h0);
    check("bad opcode pc", pc, 32'hC);
    check("bad opcode illegal", 32'(illegal), 32'd0);
    run_instr("r13 intact", 32'h01A09020, 3, 32'h5);
    run_instr("bad funct", 32'h0000003F, 1, 32'h0);
    check("bad funct pc", pc, 32'h14);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
